dec_counter_core: RTL and testbench

- Counter core that generates the counter$count (32-bit) and counter$overflow values consumed by the mkTb-level checker.
- Implements the upstream counting stage: a run/pause-controlled up/down counter with synchronous load, configurable wrap point and overflow reporting.
- Method-style EN_/RDY_ handshakes match the BSV-generated modules in the same design.

---
 rtl/dec_counter_core.sv | 119 +++++++++++
 tb/tb_dec_counter_core.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/dec_counter_core.sv
// Run/pause-controlled up/down counter with synchronous load, configurable wrap point
// and registered overflow pulse plus sticky overflow flag, using EN_/RDY_ method handshakes.
module dec_counter_core #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN_start,
  output logic             RDY_start,
  input  logic             EN_stop,
  output logic             RDY_stop,
  input  logic             EN_load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic             EN_clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             overflow_sticky,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StPaused = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             sticky_q, sticky_d;

  logic             running;
  logic             do_start;
  logic             do_stop;
  logic             do_step;
  logic             step_wraps;
  logic [WIDTH-1:0] step_value;
  logic [WIDTH-1:0] load_clamped;

  assign running   = (state_q == StRun);
  assign RDY_start = ~running;
  assign RDY_stop  = running;

  // Requests that are not ready are dropped here, so the FSM never sees them.
  assign do_start = EN_start & ~running;
  assign do_stop  = EN_stop & running;
  assign do_step  = running & ~EN_load & ~do_stop;

  assign load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

  always_comb begin
    step_wraps = 1'b0;
    step_value = count_q;
    if (dir) begin
      if (count_q == '0) begin
        step_value = MAX_COUNT;
        step_wraps = 1'b1;
      end else begin
        step_value = count_q - WIDTH'(1);
      end
    end else begin
      if (count_q == MAX_COUNT) begin
        step_value = '0;
        step_wraps = 1'b1;
      end else begin
        step_value = count_q + WIDTH'(1);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ovf_d    = 1'b0;
    sticky_d = sticky_q;

    if (EN_load) begin
      count_d = load_clamped;
    end else if (do_step) begin
      count_d = step_value;
      ovf_d   = step_wraps;
    end

    // Set beats clear when a wrap and a clear land on the same edge.
    if (ovf_d) begin
      sticky_d = 1'b1;
    end else if (EN_clr_ovf) begin
      sticky_d = 1'b0;
    end

    unique case (state_q)
      StIdle, StPaused: if (do_start) state_d = StRun;
      StRun:            if (do_stop) state_d = StPaused;
      default:          state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      sticky_q <= sticky_d;
    end
  end

  assign count           = count_q;
  assign overflow        = ovf_q;
  assign overflow_sticky = sticky_q;
  assign state           = state_q;

endmodule

// File: tb/tb_dec_counter_core.sv
// Directed self-checking bench for dec_counter_core: full-range instance plus a
// MAX_COUNT=9 instance for wrap-point and load-clamp behaviour.
module tb_dec_counter_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Full-range instance
  logic        rst, en_start, en_stop, en_load, dir, en_clr;
  logic [31:0] load_value;
  logic        rdy_start, rdy_stop, overflow, sticky;
  logic [31:0] count;
  logic [1:0]  state;

  // MAX_COUNT = 9 instance
  logic        rst9, en_start9, en_stop9, en_load9, dir9, en_clr9;
  logic [31:0] load_value9;
  logic        rdy_start9, rdy_stop9, overflow9, sticky9;
  logic [31:0] count9;
  logic [1:0]  state9;

  dec_counter_core dut (
    .CLK(clk), .RST(rst), .EN_start(en_start), .RDY_start(rdy_start),
    .EN_stop(en_stop), .RDY_stop(rdy_stop), .EN_load(en_load), .load_value(load_value),
    .dir(dir), .EN_clr_ovf(en_clr), .count(count), .overflow(overflow),
    .overflow_sticky(sticky), .state(state)
  );

  dec_counter_core #(.WIDTH(32), .MAX_COUNT(32'd9)) dut9 (
    .CLK(clk), .RST(rst9), .EN_start(en_start9), .RDY_start(rdy_start9),
    .EN_stop(en_stop9), .RDY_stop(rdy_stop9), .EN_load(en_load9), .load_value(load_value9),
    .dir(dir9), .EN_clr_ovf(en_clr9), .count(count9), .overflow(overflow9),
    .overflow_sticky(sticky9), .state(state9)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    {rst, en_start, en_stop, en_load, dir, en_clr} = 6'b100000;
    load_value = '0;
    {rst9, en_start9, en_stop9, en_load9, dir9, en_clr9} = 6'b100000;
    load_value9 = '0;

    // Reset
    tick();
    rst = 1'b0;
    chk("rst_count", count, 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_sticky", 32'(sticky), 32'd0);
    chk("rst_rdy_start", 32'(rdy_start), 32'd1);
    chk("rst_rdy_stop", 32'(rdy_stop), 32'd0);

    // EN_stop in IDLE is ignored
    en_stop = 1'b1; tick(); en_stop = 1'b0;
    chk("idle_stop_ignored", 32'(state), 32'd0);

    // Start, one cycle of latency before the first step
    en_start = 1'b1; tick(); en_start = 1'b0;
    chk("start_state", 32'(state), 32'd1);
    chk("start_count", count, 32'd0);
    for (int i = 1; i <= 101; i++) begin
      tick();
      chk("up_count", count, 32'(i));
    end
    chk("up_ovf", 32'(overflow), 32'd0);
    chk("up_sticky", 32'(sticky), 32'd0);
    chk("up_state", 32'(state), 32'd1);

    // Load near top, wrap up
    en_load = 1'b1; load_value = 32'hFFFF_FFFE; tick(); en_load = 1'b0;
    chk("load_top", count, 32'hFFFF_FFFE);
    tick();
    chk("top_ffff", count, 32'hFFFF_FFFF);
    chk("top_ovf0", 32'(overflow), 32'd0);
    tick();
    chk("wrap_count", count, 32'd0);
    chk("wrap_ovf", 32'(overflow), 32'd1);
    chk("wrap_sticky", 32'(sticky), 32'd1);
    tick();
    chk("post_wrap_count", count, 32'd1);
    chk("post_wrap_ovf", 32'(overflow), 32'd0);
    chk("post_wrap_sticky", 32'(sticky), 32'd1);
    en_clr = 1'b1; tick(); en_clr = 1'b0;
    chk("clr_sticky", 32'(sticky), 32'd0);
    chk("clr_count", count, 32'd2);

    // Pause at 5 and resume
    tick(); tick(); tick();
    chk("pre_stop_count", count, 32'd5);
    en_stop = 1'b1; tick(); en_stop = 1'b0;
    chk("stop_count", count, 32'd5);
    chk("stop_state", 32'(state), 32'd2);
    chk("stop_rdy_start", 32'(rdy_start), 32'd1);
    chk("stop_rdy_stop", 32'(rdy_stop), 32'd0);
    tick();
    chk("paused_hold", count, 32'd5);
    en_start = 1'b1; tick(); en_start = 1'b0;
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_count", count, 32'd5);
    tick();
    chk("resume_step", count, 32'd6);

    // Same-edge load and stop
    en_load = 1'b1; en_stop = 1'b1; load_value = 32'd42; tick();
    en_load = 1'b0; en_stop = 1'b0;
    chk("load_stop_count", count, 32'd42);
    chk("load_stop_state", 32'(state), 32'd2);
    en_start = 1'b1; tick(); en_start = 1'b0;
    tick();
    chk("after_resume_43", count, 32'd43);

    // Down wrap coinciding with clear: set wins
    en_load = 1'b1; load_value = 32'd0; dir = 1'b1; tick(); en_load = 1'b0;
    chk("load_zero", count, 32'd0);
    en_clr = 1'b1; tick(); en_clr = 1'b0;
    chk("down_wrap_count", count, 32'hFFFF_FFFF);
    chk("down_wrap_ovf", 32'(overflow), 32'd1);
    chk("wrap_vs_clr_sticky", 32'(sticky), 32'd1);

    // Reset mid-run at 37
    en_load = 1'b1; load_value = 32'd37; dir = 1'b0; tick(); en_load = 1'b0;
    chk("load_37", count, 32'd37);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_count", count, 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    chk("midrst_sticky", 32'(sticky), 32'd0);
    tick();
    chk("midrst_idle_hold", count, 32'd0);

    // MAX_COUNT = 9 instance
    tick();
    rst9 = 1'b0;
    chk("m9_rst_count", count9, 32'd0);
    en_start9 = 1'b1; tick(); en_start9 = 1'b0;
    chk("m9_state", 32'(state9), 32'd1);
    en_load9 = 1'b1; load_value9 = 32'd1; dir9 = 1'b1; tick(); en_load9 = 1'b0;
    chk("m9_load1", count9, 32'd1);
    tick();
    chk("m9_down0", count9, 32'd0);
    chk("m9_down0_ovf", 32'(overflow9), 32'd0);
    tick();
    chk("m9_wrap9", count9, 32'd9);
    chk("m9_wrap_ovf", 32'(overflow9), 32'd1);
    chk("m9_wrap_sticky", 32'(sticky9), 32'd1);
    tick();
    chk("m9_down8", count9, 32'd8);
    chk("m9_down8_ovf", 32'(overflow9), 32'd0);
    en_load9 = 1'b1; load_value9 = 32'd15; tick(); en_load9 = 1'b0;
    chk("m9_clamp", count9, 32'd9);
    chk("m9_clamp_ovf", 32'(overflow9), 32'd0);
    dir9 = 1'b0; tick();
    chk("m9_up_wrap", count9, 32'd0);
    chk("m9_up_wrap_ovf", 32'(overflow9), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
